// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM port among per-core I/D request channels
module ram_arbiter #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*DATA_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS*DATA_W-1:0]   iload,
    output logic [CPUS*DATA_W-1:0]   dload,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    input  logic [DATA_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'b10;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   gcore, gcore_n;
    logic [GW-1:0]   rr_last, rr_last_n;
    logic            gdata, gdata_n;

    logic [CPUS-1:0] req;
    logic            access;
    logic            win_found;
    logic [GW-1:0]   win_core;
    logic            win_data;

    logic              sel_iren;
    logic              sel_dren;
    logic              sel_dwen;
    logic [ADDR_W-1:0] sel_iaddr;
    logic [ADDR_W-1:0] sel_daddr;
    logic [DATA_W-1:0] sel_dstore;

    assign req    = iREN | dREN | dWEN;
    assign access = (ramstate == RAM_ACCESS);

    // Offset k=1 is the core right after the last one served; the smallest offset with a request wins.
    always_comb begin
        win_found = 1'b0;
        win_core  = '0;
        win_data  = 1'b0;
        for (int k = 1; k <= CPUS; k++) begin
            for (int n = 0; n < CPUS; n++) begin
                if (!win_found && req[n] && (((int'(rr_last) + k) % CPUS) == n)) begin
                    win_found = 1'b1;
                    win_core  = GW'(n);
                    win_data  = dREN[n] | dWEN[n];
                end
            end
        end
    end

    always_comb begin
        sel_iren   = 1'b0;
        sel_dren   = 1'b0;
        sel_dwen   = 1'b0;
        sel_iaddr  = '0;
        sel_daddr  = '0;
        sel_dstore = '0;
        for (int n = 0; n < CPUS; n++) begin
            if (gcore == GW'(n)) begin
                sel_iren   = iREN[n];
                sel_dren   = dREN[n];
                sel_dwen   = dWEN[n];
                sel_iaddr  = iaddr[n*ADDR_W +: ADDR_W];
                sel_daddr  = daddr[n*ADDR_W +: ADDR_W];
                sel_dstore = dstore[n*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            gcore   <= '0;
            gdata   <= 1'b0;
            rr_last <= GW'(CPUS - 1);
        end else begin
            state   <= state_n;
            gcore   <= gcore_n;
            gdata   <= gdata_n;
            rr_last <= rr_last_n;
        end
    end

    always_comb begin
        state_n   = state;
        gcore_n   = gcore;
        gdata_n   = gdata;
        rr_last_n = rr_last;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = GRANT;
                    gcore_n = win_core;
                    gdata_n = win_data;
                end
            end
            GRANT: begin
                if (gdata) begin
                    ramWEN   = sel_dwen;
                    ramREN   = sel_dren & ~sel_dwen;
                    ramaddr  = sel_daddr;
                    ramstore = sel_dstore;
                end else begin
                    ramREN   = 1'b1;
                    ramaddr  = sel_iaddr;
                end
                // Completion beats abort when both happen in the same cycle.
                if (access) begin
                    state_n   = IDLE;
                    rr_last_n = gcore;
                end else if (gdata ? !(sel_dren | sel_dwen) : !sel_iren) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        iwait = '1;
        dwait = '1;
        iload = '0;
        dload = '0;
        for (int n = 0; n < CPUS; n++) begin
            if (state == GRANT && access && gcore == GW'(n)) begin
                if (gdata) begin
                    dwait[n] = 1'b0;
                    if (!sel_dwen) begin
                        dload[n*DATA_W +: DATA_W] = ramload;
                    end
                end else begin
                    iwait[n] = 1'b0;
                    iload[n*DATA_W +: DATA_W] = ramload;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and randomized checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;

    localparam int CPUS = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic                 CLK;
    logic                 nRST;
    logic [CPUS-1:0]      iREN, dREN, dWEN;
    logic [CPUS*AW-1:0]   iaddr, daddr;
    logic [CPUS*DW-1:0]   dstore;
    logic [CPUS-1:0]      iwait, dwait;
    logic [CPUS*DW-1:0]   iload, dload;
    logic                 ramREN, ramWEN;
    logic [AW-1:0]        ramaddr;
    logic [DW-1:0]        ramstore;
    logic [DW-1:0]        ramload;
    logic [1:0]           ramstate;

    ram_arbiter #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    // Model: which core/channel currently owns the RAM (if any) and who was served last.
    bit m_busy;
    int m_core;
    bit m_data;
    int m_last;
    bit n_busy;
    int n_core;
    bit n_data;
    int n_last;

    logic [CPUS-1:0]    s_iwait, s_dwait;
    logic [CPUS*DW-1:0] s_iload, s_dload;
    logic               s_ramREN, s_ramWEN;
    logic [AW-1:0]      s_ramaddr;
    logic [DW-1:0]      s_ramstore;
    int                 served[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        s_iwait    = iwait;
        s_dwait    = dwait;
        s_iload    = iload;
        s_dload    = dload;
        s_ramREN   = ramREN;
        s_ramWEN   = ramWEN;
        s_ramaddr  = ramaddr;
        s_ramstore = ramstore;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_core = 0;
        m_data = 1'b0;
        m_last = CPUS - 1;
    endtask

    task automatic check_model();
        logic [CPUS-1:0]    e_iwait, e_dwait;
        logic [CPUS*DW-1:0] e_iload, e_dload;
        logic               e_ren, e_wen;
        logic [AW-1:0]      e_addr;
        logic [DW-1:0]      e_store;
        int c;
        e_iwait = '1;
        e_dwait = '1;
        e_iload = '0;
        e_dload = '0;
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = '0;
        e_store = '0;
        c = m_core;
        if (m_busy && m_data) begin
            e_wen   = dWEN[c];
            e_ren   = dREN[c] && !dWEN[c];
            e_addr  = daddr[c*AW +: AW];
            e_store = dstore[c*DW +: DW];
            if (ramstate == ACCESS) begin
                e_dwait[c] = 1'b0;
                e_dload[c*DW +: DW] = dWEN[c] ? '0 : ramload;
            end
        end else if (m_busy) begin
            e_ren  = 1'b1;
            e_addr = iaddr[c*AW +: AW];
            if (ramstate == ACCESS) begin
                e_iwait[c] = 1'b0;
                e_iload[c*DW +: DW] = ramload;
            end
        end
        chk("ramREN",   128'(s_ramREN),   128'(e_ren));
        chk("ramWEN",   128'(s_ramWEN),   128'(e_wen));
        chk("ramaddr",  128'(s_ramaddr),  128'(e_addr));
        chk("ramstore", 128'(s_ramstore), 128'(e_store));
        chk("iwait",    128'(s_iwait),    128'(e_iwait));
        chk("dwait",    128'(s_dwait),    128'(e_dwait));
        chk("iload",    128'(s_iload),    128'(e_iload));
        chk("dload",    128'(s_dload),    128'(e_dload));
    endtask

    task automatic model_next();
        bit found;
        n_busy = m_busy;
        n_core = m_core;
        n_data = m_data;
        n_last = m_last;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= CPUS; k++) begin
                int n;
                n = (m_last + k) % CPUS;
                if (!found && (iREN[n] || dREN[n] || dWEN[n])) begin
                    found  = 1'b1;
                    n_busy = 1'b1;
                    n_core = n;
                    n_data = dREN[n] || dWEN[n];
                end
            end
        end else if (ramstate == ACCESS) begin
            n_busy = 1'b0;
            n_last = m_core;
        end else if (m_data ? !(dREN[m_core] || dWEN[m_core]) : !iREN[m_core]) begin
            n_busy = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge CLK);
        sample();
        check_model();
        model_next();
        @(posedge CLK);
        if (!nRST) begin
            model_reset();
        end else begin
            m_busy = n_busy;
            m_core = n_core;
            m_data = n_data;
            m_last = n_last;
        end
        #1;
    endtask

    task automatic clear_req();
        iREN = '0;
        dREN = '0;
        dWEN = '0;
    endtask

    initial begin
        nRST     = 1'b0;
        clear_req();
        iaddr    = '0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
        model_reset();
        #2;
        sample();
        chk("reset_ramREN", 128'(s_ramREN), 128'(0));
        chk("reset_iwait",  128'(s_iwait),  128'(3'b111));
        chk("reset_dwait",  128'(s_dwait),  128'(3'b111));
        step();
        step();
        nRST = 1'b1;
        step();

        // Single instruction read with two BUSY cycles before ACCESS
        iREN[0] = 1'b1;
        iaddr[0*AW +: AW] = 32'h40;
        step();
        ramstate = BUSY;
        step();
        chk("ifetch_ren",  128'(s_ramREN),  128'(1));
        chk("ifetch_addr", 128'(s_ramaddr), 128'(32'h40));
        step();
        ramstate = ACCESS;
        ramload  = 32'hDEADBEEF;
        step();
        chk("ifetch_iwait", 128'(s_iwait), 128'(3'b110));
        chk("ifetch_iload", 128'(s_iload[0*DW +: DW]), 128'(32'hDEADBEEF));
        iREN = '0;
        ramstate = FREE;
        step();
        chk("ifetch_done", 128'(s_iwait), 128'(3'b111));

        // Data before instruction within a core
        iREN[0] = 1'b1;
        dREN[0] = 1'b1;
        daddr[0*AW +: AW] = 32'h80;
        ramstate = ACCESS;
        step();
        step();
        chk("prio_daddr", 128'(s_ramaddr), 128'(32'h80));
        chk("prio_dwait", 128'(s_dwait),   128'(3'b110));
        chk("prio_iwait", 128'(s_iwait),   128'(3'b111));
        dREN[0] = 1'b0;
        step();
        chk("prio_bubble", 128'(s_ramREN), 128'(0));
        step();
        chk("prio_iaddr", 128'(s_ramaddr), 128'(32'h40));
        chk("prio_iwait2", 128'(s_iwait),  128'(3'b110));
        clear_req();
        step();

        // Round-robin: core0 was served last, so core1 leads and they alternate
        dREN[0] = 1'b1;
        dREN[1] = 1'b1;
        daddr[1*AW +: AW] = 32'h200;
        served.delete();
        for (int i = 0; i < 8; i++) begin
            step();
            for (int n = 0; n < CPUS; n++) begin
                if (!s_dwait[n]) served.push_back(n);
            end
        end
        chk("rr_count", 128'(served.size()), 128'(4));
        if (served.size() > 0) chk("rr_first", 128'(served[0]), 128'(1));
        for (int i = 1; i < served.size(); i++) begin
            chk("rr_alternate", 128'(served[i] != served[i-1]), 128'(1));
        end
        clear_req();
        step();

        // Write wins over read on the same data channel
        dWEN[1] = 1'b1;
        dREN[1] = 1'b1;
        daddr[1*AW +: AW]  = 32'h100;
        dstore[1*DW +: DW] = 32'h1234;
        ramstate = BUSY;
        ramload  = 32'h5555AAAA;
        step();
        step();
        chk("wr_wen",   128'(s_ramWEN),   128'(1));
        chk("wr_ren",   128'(s_ramREN),   128'(0));
        chk("wr_store", 128'(s_ramstore), 128'(32'h1234));
        chk("wr_addr",  128'(s_ramaddr),  128'(32'h100));
        ramstate = ACCESS;
        step();
        chk("wr_dwait", 128'(s_dwait), 128'(3'b101));
        chk("wr_dload", 128'(s_dload[1*DW +: DW]), 128'(0));
        clear_req();
        ramstate = FREE;
        step();

        // Abort leaves rr_last at core1, so core0 beats core1 afterwards
        iREN[0] = 1'b1;
        iaddr[0*AW +: AW] = 32'h44;
        ramstate = BUSY;
        step();
        step();
        chk("abort_grant", 128'(s_ramaddr), 128'(32'h44));
        iREN[0] = 1'b0;
        step();
        chk("abort_iwait", 128'(s_iwait), 128'(3'b111));
        iREN[0] = 1'b1;
        dREN[1] = 1'b1;
        daddr[1*AW +: AW] = 32'h300;
        step();
        chk("abort_idle", 128'(s_ramREN), 128'(0));
        step();
        chk("abort_next_ren",  128'(s_ramREN),  128'(1));
        chk("abort_next_addr", 128'(s_ramaddr), 128'(32'h44));

        // Asynchronous reset while granted
        #2;
        nRST = 1'b0;
        #1;
        sample();
        model_reset();
        chk("areset_ren",   128'(s_ramREN),  128'(0));
        chk("areset_addr",  128'(s_ramaddr), 128'(0));
        chk("areset_iwait", 128'(s_iwait),   128'(3'b111));
        chk("areset_dwait", 128'(s_dwait),   128'(3'b111));
        step();
        nRST = 1'b1;
        clear_req();
        dREN = '1;
        daddr[0*AW +: AW] = 32'hA0;
        step();
        step();
        chk("areset_first", 128'(s_ramaddr), 128'(32'hA0));
        clear_req();
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < CPUS; n++) begin
                if ($urandom_range(0, 5) == 0) iREN[n] = ~iREN[n];
                if ($urandom_range(0, 5) == 0) dREN[n] = ~dREN[n];
                if ($urandom_range(0, 9) == 0) dWEN[n] = ~dWEN[n];
            end
            iaddr    = {$urandom, $urandom, $urandom};
            daddr    = {$urandom, $urandom, $urandom};
            dstore   = {$urandom, $urandom, $urandom};
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Multi-core arbiter that shares the single RAM port among CPUS cores, each with an instruction and a data request channel.
- Selects one requester at a time using round-robin across cores, with data before instruction within a core.
- Holds the grant until RAM reports ACCESS, then returns the response to the winner only.
- Sits between the per-core cache controllers and the RAM model; sequences all RAM traffic for the multi-core system.

Parameters:
- CPUS, 2, number of cores sharing RAM (1..4).
- ADDR_W, 32, address width (word_t).
- DATA_W, 32, data width (word_t).

Ports:
- CLK  in  1  system clock, rising-edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  CPUS  per-core instruction read request.
- dREN  in  CPUS  per-core data read request.
- dWEN  in  CPUS  per-core data write request.
- iaddr  in  CPUS*ADDR_W  per-core instruction address; core n at bits [n*ADDR_W +: ADDR_W].
- daddr  in  CPUS*ADDR_W  per-core data address.
- dstore  in  CPUS*DATA_W  per-core write data.
- iwait  out  CPUS  per-core instruction wait; 0 only in the completion cycle.
- dwait  out  CPUS  per-core data wait; 0 only in the completion cycle.
- iload  out  CPUS*DATA_W  per-core instruction read data.
- dload  out  CPUS*DATA_W  per-core data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Registers:
  - state: IDLE, GRANT.
  - gcore: granted core index, clog2(CPUS) bits, min 1.
  - gdata: 1 = data channel, 0 = instruction channel.
  - rr_last: last served core.
- Reset (async, nRST=0):
  - state=IDLE, gcore=0, gdata=0, rr_last=CPUS-1, so core 0 has first priority.
  - Outputs during and after reset: all iwait/dwait=1, all iload/dload=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- Core request: core n requests if dREN[n]|dWEN[n]|iREN[n].
- Winner selection (combinational, used in IDLE only):
  - Search cores rr_last+1, rr_last+2, … modulo CPUS; first requesting core wins.
  - Within the winning core, the data channel wins if dREN|dWEN, else the instruction channel.
- IDLE:
  - RAM enables are 0.
  - If any core requests, latch gcore/gdata at the edge and go to GRANT.
  - No response is given in IDLE.
- GRANT:
  - Data channel: ramWEN=dWEN[gcore]; ramREN=dREN[gcore]&~dWEN[gcore] (write wins if both asserted). ramaddr=daddr[gcore]; ramstore=dstore[gcore].
  - Instruction channel: ramREN=1, ramWEN=0, ramaddr=iaddr[gcore], ramstore=0.
  - When ramstate==ACCESS, combinationally in that cycle:
    - Deassert dwait[gcore] (data) or iwait[gcore] (instr).
    - Drive ramload onto dload[gcore] (data read) or iload[gcore] (instr); data writes return dload=0.
    - At the edge: rr_last<=gcore, state<=IDLE.
  - Abort: if the granted channel's request drops (data: dREN|dWEN=0; instr: iREN=0) before ACCESS, go to IDLE with no wait deassertion and leave rr_last unchanged. The ACCESS check takes precedence over abort in the same cycle.
  - FREE, BUSY and ERROR keep the grant (retry; no error reporting).
- Latency:
  - Request seen in IDLE at cycle t → RAM enables asserted from cycle t+1.
  - Completion at the first ACCESS cycle ≥ t+1.
  - Next grant: one IDLE bubble cycle after each completion.
- Non-granted channels: wait=1 and load=0 at all times.
- Grant is stable: gcore/gdata never change while in GRANT. A core raising dREN while its instruction read is granted waits for the next arbitration.
- CPUS=1: reduces to a single core with data-over-instruction priority plus the bubble cycle.
- Mid-operation reset: immediate return to the reset values; no response is delivered.

Test Plan:
- Single instruction read: core0 iREN=1, iaddr=0x40, RAM ACCESS 2 cycles after grant with ramload=0xDEADBEEF → ramREN=1, ramaddr=0x40 from cycle 1; iwait[0]=0 and iload[0]=0xDEADBEEF for exactly one cycle; then IDLE.
- Intra-core priority: core0 iREN=1, dREN=1, daddr=0x80 simultaneously → data served first (ramaddr=0x80, dwait[0] low), then instruction at iaddr after the bubble.
- Round-robin fairness: both cores hold dREN continuously with fixed-latency RAM → grants alternate core0, core1, core0, core1; no core is served twice in a row.
- Write: core1 dWEN=1, dREN=1, daddr=0x100, dstore=0x1234 → ramWEN=1, ramREN=0, ramstore=0x1234; dwait[1]=0 on ACCESS; dload[1]=0.
- Abort: core0 granted on the instruction channel, iREN drops while ramstate=BUSY → IDLE next cycle, iwait[0] never 0, rr_last unchanged (core0 still next in line relative to core1).
- Async reset: assert nRST mid-GRANT → all enables 0 and all waits 1 immediately without a clock edge; after release, core0 wins the first simultaneous request.
